// File: rtl/drp_arbiter_pkg.sv
// drp_arbiter_pkg: FSM state encodings and fixed data values shared by the
// DRP arbiter files.
package drp_arbiter_pkg;

    localparam logic [0:0]  ST_IDLE       = 1'b0;
    localparam logic [0:0]  ST_WAIT       = 1'b1;
    localparam logic [15:0] TIMEOUT_RDATA = 16'hFFFF;

endpackage

// File: rtl/drp_arb_rr.sv
// drp_arb_rr: combinational round-robin selector. The search starts one past
// the last granted index and wraps; valid is low when nothing is requested.
module drp_arb_rr #(
    parameter int PORTS = 2,
    parameter int IW    = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [IW-1:0]    grant,
    output logic             valid
);

    always_comb begin
        logic [IW-1:0] idx;
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        // Walk from farthest to nearest so the nearest requester overwrites.
        for (int k = PORTS; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % PORTS);
            if (req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/drp_arbiter.sv
// drp_arbiter: shares one DRP port among PORTS single-pulse requesters.
// Define DRP_ARBITER_TIMEOUT_EN to build the drp_rdy watchdog.
module drp_arbiter
    import drp_arbiter_pkg::*;
#(
    parameter int PORTS      = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [PORTS*16-1:0]         req_di,
    input  logic [PORTS-1:0]            req_en,
    input  logic [PORTS-1:0]            req_we,
    output logic [15:0]                 req_do,
    output logic [PORTS-1:0]            req_rdy,
    output logic [ADDR_WIDTH-1:0]       drp_addr,
    output logic [15:0]                 drp_do,
    input  logic [15:0]                 drp_di,
    output logic                        drp_en,
    output logic                        drp_we,
    input  logic                        drp_rdy,
    output logic                        timeout
);

    localparam int IW = $clog2(PORTS);
    localparam logic [PORTS-1:0] PORT0 = {{(PORTS-1){1'b0}}, 1'b1};

    logic [0:0]            state;
    logic [IW-1:0]         last;
    logic [IW-1:0]         sel;
    logic                  sel_vld;
    logic [PORTS-1:0]      pend;
    logic [PORTS-1:0]      clr;
    logic [ADDR_WIDTH-1:0] slot_addr [PORTS];
    logic [15:0]           slot_di   [PORTS];
    logic [PORTS-1:0]      slot_we;
    logic                  rdy_ok;
    logic                  to_fire;

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("drp_arbiter: TIMEOUT must be >= 1");
    end

    // drp_rdy counts only after the drp_en cycle of the in-flight transaction.
    assign rdy_ok = (state == ST_WAIT) && drp_rdy && !drp_en;
    assign clr    = (rdy_ok || to_fire) ? (PORT0 << last) : '0;

    drp_arb_rr #(
        .PORTS (PORTS),
        .IW    (IW)
    ) u_rr (
        .req   (pend),
        .last  (last),
        .grant (sel),
        .valid (sel_vld)
    );

    // A new pulse on the port being completed is captured: set wins over clear.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PORTS; i++) begin
            if (rst) begin
                pend[i] <= 1'b0;
            end else if (req_en[i] && (!pend[i] || clr[i])) begin
                pend[i]      <= 1'b1;
                slot_addr[i] <= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                slot_di[i]   <= req_di[i*16 +: 16];
                slot_we[i]   <= req_we[i];
            end else if (clr[i]) begin
                pend[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            last     <= IW'(PORTS - 1);
            drp_en   <= 1'b0;
            drp_we   <= 1'b0;
            drp_addr <= '0;
            drp_do   <= '0;
            req_rdy  <= '0;
            req_do   <= '0;
            timeout  <= 1'b0;
        end else begin
            drp_en  <= 1'b0;
            drp_we  <= 1'b0;
            req_rdy <= '0;
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel_vld) begin
                        last     <= sel;
                        drp_addr <= slot_addr[sel];
                        drp_do   <= slot_di[sel];
                        drp_we   <= slot_we[sel];
                        drp_en   <= 1'b1;
                        state    <= ST_WAIT;
                    end
                end
                default: begin
                    if (rdy_ok) begin
                        req_do  <= drp_di;
                        req_rdy <= PORT0 << last;
                        state   <= ST_IDLE;
                    end else if (to_fire) begin
                        req_do  <= TIMEOUT_RDATA;
                        req_rdy <= PORT0 << last;
                        timeout <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef DRP_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt;

    // Loaded on the issue edge, so the drp_en cycle is the first counted one.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == ST_IDLE && sel_vld) begin
            wd_cnt <= CW'(TIMEOUT);
        end else if (state == ST_WAIT && wd_cnt != '0) begin
            wd_cnt <= wd_cnt - CW'(1);
        end
    end

    assign to_fire = (state == ST_WAIT) && !rdy_ok && (wd_cnt == '0);
`else
    assign to_fire = 1'b0;
`endif

endmodule

// File: tb/tb_drp_arbiter.sv
// tb_drp_arbiter: randomized scoreboard bench for drp_arbiter with a DRP slave
// model and a transaction-level arbiter reference.
module tb_drp_arbiter;

    localparam int P  = 4;
    localparam int AW = 16;
    localparam int TO = 8;
`ifdef DRP_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [P*AW-1:0] req_addr = '0;
    logic [P*16-1:0] req_di   = '0;
    logic [P-1:0]  req_en = '0;
    logic [P-1:0]  req_we = '0;
    logic [15:0]   req_do;
    logic [P-1:0]  req_rdy;
    logic [AW-1:0] drp_addr;
    logic [15:0]   drp_do;
    logic [15:0]   drp_di = '0;
    logic          drp_en;
    logic          drp_we;
    logic          drp_rdy = 1'b0;
    logic          timeout;

    drp_arbiter #(.PORTS(P), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_addr(req_addr), .req_di(req_di), .req_en(req_en), .req_we(req_we),
        .req_do(req_do), .req_rdy(req_rdy),
        .drp_addr(drp_addr), .drp_do(drp_do), .drp_di(drp_di),
        .drp_en(drp_en), .drp_we(drp_we), .drp_rdy(drp_rdy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          port;
        logic [15:0] data;
        bit          to;
        int          cyc;
    } cpl_t;

    cpl_t        sb[$];
    int          grants[$];
    int          cyc = 0;
    bit          started = 0;
    bit          prev_rst = 0;
    bit          m_pend [P];
    logic [AW-1:0] m_addr [P];
    logic [15:0] m_di [P];
    bit          m_we [P];
    bit          inflight = 0;
    int          inf_port = 0;
    int          issue_c = 0;
    int          m_last = P - 1;
    bit          exp_en = 0;
    logic [AW-1:0] exp_addr = '0, hold_addr = '0, last_issue_addr = '0;
    logic [15:0] exp_do = '0, hold_do = '0;
    bit          exp_we = 0;

    initial begin
        int clearing;
        int pick;
        forever begin
            @(posedge clk);
            if (rst) begin
                started  = 1;
                prev_rst = 1;
                inflight = 0;
                exp_en   = 0;
                hold_addr = '0;
                hold_do  = '0;
                m_last   = P - 1;
                for (int i = 0; i < P; i++) m_pend[i] = 0;
            end else if (started) begin
                if (prev_rst) begin
                    check("rst_drp_en", 32'(drp_en), 0);
                    check("rst_drp_we", 32'(drp_we), 0);
                    check("rst_drp_addr", 32'(drp_addr), 0);
                    check("rst_drp_do", 32'(drp_do), 0);
                    check("rst_req_do", 32'(req_do), 0);
                    check("rst_req_rdy", 32'(req_rdy), 0);
                    check("rst_timeout", 32'(timeout), 0);
                end
                if (exp_en) begin
                    check("issue_en", 32'(drp_en), 1);
                    check("issue_addr", 32'(drp_addr), 32'(exp_addr));
                    check("issue_we", 32'(drp_we), 32'(exp_we));
                    check("issue_do", 32'(drp_do), 32'(exp_do));
                    hold_addr = exp_addr;
                    hold_do   = exp_do;
                end else begin
                    check("quiet_en", 32'(drp_en), 0);
                    check("quiet_we", 32'(drp_we), 0);
                    check("hold_addr", 32'(drp_addr), 32'(hold_addr));
                    check("hold_do", 32'(drp_do), 32'(hold_do));
                end
                exp_en   = 0;
                clearing = -1;
                if (inflight) begin
                    if (drp_rdy && cyc > issue_c) begin
                        sb.push_back('{inf_port, drp_di, 1'b0, cyc + 1});
                        clearing = inf_port;
                        inflight = 0;
                    end else if (TO_EN && cyc >= issue_c + TO) begin
                        sb.push_back('{inf_port, 16'hFFFF, 1'b1, cyc + 1});
                        clearing = inf_port;
                        inflight = 0;
                    end
                end else begin
                    pick = -1;
                    for (int k = 1; k <= P; k++) begin
                        if (pick < 0 && m_pend[(m_last + k) % P]) pick = (m_last + k) % P;
                    end
                    if (pick >= 0) begin
                        exp_en   = 1;
                        exp_addr = m_addr[pick];
                        exp_do   = m_di[pick];
                        exp_we   = m_we[pick];
                        last_issue_addr = m_addr[pick];
                        inflight = 1;
                        inf_port = pick;
                        issue_c  = cyc + 1;
                        m_last   = pick;
                        grants.push_back(pick);
                    end
                end
                for (int i = 0; i < P; i++) begin
                    if (req_en[i] && (!m_pend[i] || clearing == i)) begin
                        m_pend[i] = 1;
                        m_addr[i] = req_addr[i*AW +: AW];
                        m_di[i]   = req_di[i*16 +: 16];
                        m_we[i]   = req_we[i];
                    end else if (clearing == i) begin
                        m_pend[i] = 0;
                    end
                end
                prev_rst = 0;
            end
            cyc++;
        end
    end

    // ---------------- completion monitor ----------------
    int          n_cpl = 0;
    int          n_to = 0;
    logic [15:0] last_do = '0;

    initial begin
        cpl_t e;
        forever begin
            @(negedge clk);
            if (started) begin
                if (req_rdy !== '0) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_rdy actual=%0h required=0", req_rdy);
                    end else begin
                        e = sb.pop_front();
                        check("rdy_vec", 32'(req_rdy), 32'(1) << e.port);
                        check("rdy_data", 32'(req_do), 32'(e.data));
                        check("rdy_timeout", 32'(timeout), 32'(e.to));
                        check("rdy_cycle", 32'(cyc), 32'(e.cyc));
                        last_do = req_do;
                        n_cpl++;
                        if (timeout) n_to++;
                    end
                end else begin
                    check("timeout_idle", 32'(timeout), 0);
                end
            end
        end
    end

    // ---------------- DRP slave model ----------------
    int          fixed_lat = 3;
    bit          rand_lat = 0;
    bit          noise = 0;
    bit          use_fixed = 1;
    logic [15:0] fixed_data = 16'hBEEF;
    int          mute_tok = 0;

    initial begin
        int cnt = 0;
        bit busy = 0;
        int mute_done = 0;
        forever begin
            @(negedge clk);
            drp_rdy = 1'b0;
            if (drp_en === 1'b1) begin
                busy = (mute_tok <= mute_done);
                if (mute_tok > mute_done) mute_done++;
                cnt = rand_lat ? int'($urandom_range(5, 1)) : fixed_lat;
                if (noise && $urandom_range(3, 0) == 0) begin
                    drp_rdy = 1'b1;
                    drp_di  = 16'($urandom);
                end
            end else if (busy) begin
                cnt--;
                if (cnt <= 0) begin
                    busy    = 0;
                    drp_rdy = 1'b1;
                    drp_di  = use_fixed ? fixed_data : 16'($urandom);
                end
            end else if (noise && $urandom_range(7, 0) == 0) begin
                drp_rdy = 1'b1;
                drp_di  = 16'($urandom);
            end
        end
    end

    // ---------------- stimulus ----------------
    bit auto_rr = 0;

    task automatic issue(input int p, input logic [15:0] a, input logic [15:0] d, input bit we);
        req_en[p]            = 1'b1;
        req_we[p]            = we;
        req_addr[p*AW +: AW] = a;
        req_di[p*16 +: 16]   = d;
    endtask

    task automatic tick();
        @(negedge clk);
        req_en = '0;
        if (auto_rr) begin
            for (int i = 0; i < P; i++)
                if (req_rdy[i]) issue(i, 16'(16'h0300 + i), 16'($urandom), 1'b0);
        end
    endtask

    function automatic bit model_idle();
        if (sb.size() != 0 || inflight || exp_en) return 0;
        for (int i = 0; i < P; i++) if (m_pend[i]) return 0;
        return 1;
    endfunction

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        tick();
        while (!model_idle() && n < budget) begin
            tick();
            n++;
        end
        tick();
        tick();
        check(name, 32'(model_idle()), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int base;
        int n;
        int exp_order [6] = '{0, 1, 2, 3, 0, 1};
        repeat (3) tick();
        rst = 1'b0;

        // single read, fixed 3-cycle DRP latency returning BEEF
        tick();
        issue(0, 16'h0042, 16'h0000, 1'b0);
        wait_idle(50, "read_done");
        check("read_data", 32'(last_do), 32'hBEEF);

        // simultaneous writes on ports 0 and 1 from reset priority
        use_fixed = 0;
        do_reset();
        grants.delete();
        base = n_cpl;
        tick();
        issue(0, 16'h0010, 16'h1111, 1'b1);
        issue(1, 16'h0011, 16'h2222, 1'b1);
        wait_idle(60, "writes_done");
        check("writes_count", 32'(n_cpl - base), 2);
        check("writes_first", 32'(grants[0]), 0);
        check("writes_second", 32'(grants[1]), 1);

        // fairness with immediate re-requests
        do_reset();
        grants.delete();
        tick();
        for (int i = 0; i < P; i++) issue(i, 16'(16'h0200 + i), 16'($urandom), 1'b0);
        auto_rr = 1;
        n = 0;
        while (grants.size() < 6 && n < 200) begin
            tick();
            n++;
        end
        auto_rr = 0;
        wait_idle(100, "fair_done");
        check("fair_count", 32'(grants.size() >= 6), 1);
        for (int k = 0; k < 6; k++)
            if (k < grants.size()) check("fair_order", 32'(grants[k]), 32'(exp_order[k]));

        // second pulse while pending is dropped
        grants.delete();
        tick();
        issue(1, 16'h0100, 16'hAAAA, 1'b1);
        tick();
        issue(1, 16'h0200, 16'h5555, 1'b0);
        wait_idle(60, "drop_done");
        check("drop_grants", 32'(grants.size()), 1);
        check("drop_addr", 32'(last_issue_addr), 32'h0100);

`ifdef DRP_ARBITER_TIMEOUT_EN
        // watchdog: first transaction never answered, next proceeds normally
        base = n_to;
        mute_tok++;
        grants.delete();
        tick();
        issue(2, 16'h0522, 16'h1234, 1'b0);
        issue(3, 16'h0533, 16'h4321, 1'b1);
        wait_idle(100, "wd_done");
        check("wd_pulses", 32'(n_to - base), 1);
        check("wd_grants", 32'(grants.size()), 2);
`endif

        // reset while waiting for drp_rdy, followed by a late drp_rdy
        fixed_lat = 6;
        base = n_cpl;
        tick();
        issue(0, 16'h0777, 16'h0000, 1'b0);
        n = 0;
        while (drp_en !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("rstw_issue_seen", 32'(drp_en), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        check("rstw_no_rdy", 32'(n_cpl - base), 0);
        fixed_lat = 2;
        tick();
        issue(1, 16'h0888, 16'h9999, 1'b1);
        wait_idle(50, "rstw_done");
        check("rstw_next", 32'(n_cpl - base), 1);

        // randomized traffic with variable latency and stray drp_rdy
        rand_lat = 1;
        noise    = 1;
        repeat (400) begin
            tick();
            for (int i = 0; i < P; i++)
                if ($urandom_range(5, 0) == 0)
                    issue(i, 16'($urandom), 16'($urandom), 1'($urandom));
        end
        noise = 0;
        wait_idle(300, "random_done");
        check("drain", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/drp_arbiter.md
# drp_arbiter

Round-robin arbiter that shares one Xilinx DRP port (transceiver, MMCM, XADC) among several DRP-style requesters, e.g. multiple Wishbone-to-DRP shims or local configuration state machines. Each requester issues single-cycle `en` pulses. The arbiter latches each request, serializes the requests onto the shared DRP port one at a time, and routes `drp_rdy` and read data back to the originator. An optional watchdog completes transactions that never receive `drp_rdy`.

## Interface
- `PORTS`, default 2: number of requesters, 2..16.
- `ADDR_WIDTH`, default 16: DRP address width.
- `TIMEOUT`, default 255: watchdog limit in clock cycles, counted from `drp_en`. Must be ≥1. Used only with the timeout feature.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_addr`  in  PORTS*ADDR_WIDTH  per-port address; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_di`  in  PORTS*16  per-port write data.
- `req_en`  in  PORTS  per-port request strobe, one cycle.
- `req_we`  in  PORTS  per-port write qualifier, sampled with `req_en`.
- `req_do`  out  16  read data, shared by all ports; valid only while some `req_rdy` bit is high.
- `req_rdy`  out  PORTS  per-port completion pulse, one cycle.
- `drp_addr`  out  ADDR_WIDTH  shared DRP address.
- `drp_do`  out  16  shared DRP write data.
- `drp_di`  in  16  shared DRP read data.
- `drp_en`  out  1  DRP enable.
- `drp_we`  out  1  DRP write enable.
- `drp_rdy`  in  1  DRP ready.
- `timeout`  out  1  one-cycle pulse when a transaction is force-completed.

## Operation
- Each port has a pending slot holding addr, data and we, plus a `pend[i]` flag.
  - A `req_en[i]` pulse while `pend[i]`=0 captures the request and sets `pend[i]`.
  - A `req_en[i]` pulse while `pend[i]`=1 is dropped. The slot is not altered.
- FSM states: IDLE, WAIT.
- IDLE with any `pend` set:
  - Select the port by round robin. The search starts at `last+1` mod PORTS, where `last` is the previously granted port. `last` resets to PORTS-1, so port 0 has first priority.
  - Register `drp_addr`, `drp_do` and `drp_we` from the selected slot, pulse `drp_en` for one cycle, then go to WAIT.
- WAIT:
  - On `drp_rdy`: capture `drp_di` into `req_do`, pulse `req_rdy[g]`, clear `pend[g]`, go to IDLE.
  - `drp_rdy` is honoured from the cycle after `drp_en` onward.
- `drp_rdy` in IDLE, or in the same cycle as `drp_en`, is ignored.
- Same-cycle `req_en[g]` and clear of `pend[g]`: set wins, and the new request is captured.
- `drp_we` is high only in the cycle `drp_en` is high. `drp_addr` and `drp_do` hold their values until the next issue.

## Timing
- Reset values: `drp_en`, `drp_we`, `req_rdy`, `timeout` = 0; `drp_addr`, `drp_do`, `req_do` = 0; all `pend` = 0; state IDLE; `last` = PORTS-1.
- Reset mid-transaction abandons the in-flight transaction. No `req_rdy` is generated, and a later `drp_rdy` is ignored.
- Request pulse at cycle N: `pend` is set at N+1 and `drp_en` is high at N+2 if the arbiter is idle.
- `drp_rdy` at cycle M: `req_rdy` and `req_do` are valid at M+1. The earliest next `drp_en` is M+2.
- Throughput: one transaction per (DRP latency + 2) cycles.
- Fairness: each pending port is served within PORTS transactions.

## Configuration
- `DRP_ARBITER_TIMEOUT_EN` defined:
  - A down-counter of width $clog2(TIMEOUT+1) loads TIMEOUT at `drp_en` and decrements in WAIT.
  - If it reaches 0 without `drp_rdy`, the transaction completes with `req_rdy[g]`, `req_do` = 16'hFFFF and a one-cycle `timeout` pulse, then the FSM returns to IDLE.
  - A `drp_rdy` arriving in the same cycle the counter hits 0 wins: normal completion, no `timeout` pulse.
- `DRP_ARBITER_TIMEOUT_EN` undefined: WAIT lasts indefinitely, `timeout` is tied to 0, and no counter is built.

## Structure
- Shared package/header: FSM state encodings (IDLE=0, WAIT=1) and the timeout read-data constant 16'hFFFF.
- One sub-module, `drp_arb_rr`: a combinational round-robin priority selector.
  - Inputs: request vector and `last`.
  - Outputs: grant index and a valid flag.
- Slot storage, FSM and watchdog live in `drp_arbiter`.

## Test plan
- Single read on port 0, addr 16'h0042, DRP model returns 16'hBEEF 3 cycles after `drp_en`:
  - `drp_en` at N+2 with `drp_we`=0.
  - `req_rdy[0]` with `req_do`=16'hBEEF one cycle after `drp_rdy`.
- Simultaneous writes on ports 0 and 1 (16'h1111, 16'h2222), PORTS=2:
  - Two DRP cycles, port 0 first, then port 1.
  - Each `req_rdy` bit pulses exactly once.
- Fairness, all 4 ports re-requesting immediately after each `req_rdy`, PORTS=4: grant order is 0,1,2,3,0,1 with no port skipped.
- Second `req_en[1]` while `pend[1]` is set, with different data: only the first request reaches the DRP port.
- Watchdog, macro defined, TIMEOUT=8, DRP model never responds:
  - `req_rdy` with `req_do`=16'hFFFF and a `timeout` pulse 9 cycles after `drp_en`.
  - The next pending request then issues normally.
- `rst` asserted in WAIT, followed by a late `drp_rdy`: no `req_rdy`, all outputs at reset values, and the next request proceeds normally.
